seq_alu: RTL and testbench

- Parametrised multi-cycle ALU; successor to the single-cycle combinational datapath ALU.
- Adds a start/done handshake, a sequential signed multiplier (radix-2 Booth) and a sequential signed divider.
- Results go to a registered HI/LO pair feeding the HI, LO and Z datapath registers.
- Sits between the A/B operand registers and the Z register, under control-unit sequencing.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/seq_muldiv.sv | 130 +++++++++++++
 rtl/seq_alu.sv | 186 ++++++++++++++++++
 tb/tb_seq_alu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU: opcode encodings, the FSM state
// encoding and a helper that classifies the ops finishing in one cycle.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_DIV  = 5'b01111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DFIX = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_single_cycle(input logic [4:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB,
      OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_NEG, OP_NOT: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// ---------------------------------------------------------------------------
// seq_muldiv
// Iterative datapath shared by MUL (radix-2 Booth) and DIV (restoring, on
// magnitudes, with a final sign fix). One step per clock for WIDTH clocks.
//
// Ports:
//   clock      in   system clock, rising edge
//   clear      in   asynchronous active-high reset
//   load       in   capture operands and start iterating
//   op_is_div  in   sampled with load: 1 = divide, 0 = multiply
//   A, B       in   operands (multiplicand/multiplier or dividend/divisor)
//   hi, lo     out  MUL: product halves, valid while fin=1 (value after the
//                   last step); DIV: remainder/quotient, valid once all steps
//                   are done (the cycle after fin)
//   fin        out  high during the cycle whose edge performs the last step
// ---------------------------------------------------------------------------
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             fin
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  // acc/m carry an extra bit: Booth needs it when the multiplicand is the
  // most negative value, restoring division needs it as the borrow bit.
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             qm1_reg;
  logic [CW-1:0]    count_reg;
  logic             div_reg;
  logic             sign_a_reg;
  logic             sign_b_reg;

  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = A[WIDTH-1] ? ('0 - A) : A;
  assign abs_b = B[WIDTH-1] ? ('0 - B) : B;

  // Booth step: add/sub on {Q0, q-1}, then arithmetic shift of {acc, Q, q-1}.
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   mul_acc_next;
  logic [WIDTH-1:0] mul_q_next;

  always_comb begin
    booth_sum = acc_reg;
    case ({q_reg[0], qm1_reg})
      2'b01:   booth_sum = acc_reg + m_reg;
      2'b10:   booth_sum = acc_reg - m_reg;
      default: booth_sum = acc_reg;
    endcase
  end

  assign mul_acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign mul_q_next   = {booth_sum[0], q_reg[WIDTH-1:1]};

  // Restoring step: shift the dividend bit into the partial remainder and
  // keep the difference only when it did not borrow.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic [WIDTH:0]   div_acc_next;
  logic [WIDTH-1:0] div_q_next;

  assign r_shift      = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign r_diff       = r_shift - m_reg;
  assign div_acc_next = r_diff[WIDTH] ? r_shift : r_diff;
  assign div_q_next   = {q_reg[WIDTH-2:0], ~r_diff[WIDTH]};

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc_reg    <= '0;
      m_reg      <= '0;
      q_reg      <= '0;
      qm1_reg    <= 1'b0;
      count_reg  <= '0;
      div_reg    <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
    end else if (load) begin
      acc_reg    <= '0;
      qm1_reg    <= 1'b0;
      count_reg  <= COUNT_INIT;
      div_reg    <= op_is_div;
      sign_a_reg <= A[WIDTH-1];
      sign_b_reg <= B[WIDTH-1];
      if (op_is_div) begin
        q_reg <= abs_a;
        m_reg <= {1'b0, abs_b};
      end else begin
        q_reg <= B;
        m_reg <= {A[WIDTH-1], A};
      end
    end else if (count_reg != '0) begin
      count_reg <= count_reg - COUNT_ONE;
      if (div_reg) begin
        acc_reg <= div_acc_next;
        q_reg   <= div_q_next;
      end else begin
        acc_reg <= mul_acc_next;
        q_reg   <= mul_q_next;
        qm1_reg <= q_reg[0];
      end
    end
  end

  assign fin = (count_reg == COUNT_ONE);

  // MUL exposes the post-step value so the caller can capture on the same
  // edge as the final step; DIV applies the sign fix to the settled registers.
  always_comb begin
    if (div_reg) begin
      hi = sign_a_reg ? ('0 - acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];
      lo = (sign_a_reg ^ sign_b_reg) ? ('0 - q_reg) : q_reg;
    end else begin
      hi = mul_acc_next[WIDTH-1:0];
      lo = mul_q_next;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Multi-cycle ALU with start/done handshake. Logic, add/sub, shift, rotate,
// negate and invert finish in one cycle; MUL and DIV iterate in seq_muldiv.
//
// Ports:
//   clock        in   system clock, rising edge
//   clear        in   asynchronous active-high reset
//   start        in   one-cycle request; opcode/A/B sampled on the same edge
//   opcode       in   operation select
//   A, B         in   operands; B[SHW-1:0] is the shift/rotate amount
//   busy         out  high while a MUL/DIV is iterating (MUL, DIV, DFIX)
//   done         out  one-cycle pulse; Zhigh/Zlow valid from this cycle
//   Zhigh        out  product high / remainder / 0
//   Zlow         out  product low / quotient / single-cycle result
//   div_by_zero  out  sticky until the next accepted start
//   illegal_op   out  sticky until the next accepted start
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Zhigh,
  output logic [WIDTH-1:0] Zlow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  import alu_pkg::*;

  state_t           state_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] zhigh_reg;
  logic [WIDTH-1:0] zlow_reg;
  logic             dbz_reg;
  logic             ill_reg;

  // ---------------- single-cycle datapath ----------------
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] ror_res;
  logic [WIDTH-1:0] rol_res;
  logic [WIDTH-1:0] alu_res;

  assign amt = B[SHW-1:0];

  // Rotates as per-bit muxes; the SHW-bit index arithmetic wraps, which is
  // exactly "amount modulo WIDTH".
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      logic [SHW-1:0] ror_idx;
      logic [SHW-1:0] rol_idx;
      assign ror_idx     = SHW'(gi) + amt;
      assign rol_idx     = SHW'(gi) - amt;
      assign ror_res[gi] = A[ror_idx];
      assign rol_res[gi] = A[rol_idx];
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SHR:  alu_res = A >> amt;
      OP_SHRA: alu_res = $signed(A) >>> amt;
      OP_SHL:  alu_res = A << amt;
      OP_ROR:  alu_res = ror_res;
      OP_ROL:  alu_res = rol_res;
      OP_NEG:  alu_res = '0 - A;
      OP_NOT:  alu_res = ~A;
      default: alu_res = '0;
    endcase
  end

  // ---------------- iterative datapath ----------------
  logic             md_load;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic             md_fin;

  // Divide-by-zero never enters the iterator; it is resolved in IDLE.
  assign md_load = (state_reg == ST_IDLE) && start &&
                   ((opcode == OP_MUL) || ((opcode == OP_DIV) && (B != '0)));

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock     (clock),
    .clear     (clear),
    .load      (md_load),
    .op_is_div (opcode == OP_DIV),
    .A         (A),
    .B         (B),
    .hi        (md_hi),
    .lo        (md_lo),
    .fin       (md_fin)
  );

  // ---------------- control FSM and output registers ----------------
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      zhigh_reg <= '0;
      zlow_reg  <= '0;
      dbz_reg   <= 1'b0;
      ill_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            dbz_reg <= 1'b0;
            ill_reg <= 1'b0;
            if (is_single_cycle(opcode)) begin
              zlow_reg  <= alu_res;
              zhigh_reg <= '0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else if (opcode == OP_MUL) begin
              busy_reg  <= 1'b1;
              state_reg <= ST_MUL;
            end else if (opcode == OP_DIV) begin
              if (B == '0) begin
                zlow_reg  <= '1;
                zhigh_reg <= A;
                dbz_reg   <= 1'b1;
                done_reg  <= 1'b1;
                state_reg <= ST_DONE;
              end else begin
                busy_reg  <= 1'b1;
                state_reg <= ST_DIV;
              end
            end else begin
              zlow_reg  <= '0;
              zhigh_reg <= '0;
              ill_reg   <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (md_fin) begin
            zhigh_reg <= md_hi;
            zlow_reg  <= md_lo;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (md_fin) state_reg <= ST_DFIX;
        end
        ST_DFIX: begin
          zhigh_reg <= md_hi;
          zlow_reg  <= md_lo;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign Zhigh       = zhigh_reg;
  assign Zlow        = zlow_reg;
  assign div_by_zero = dbz_reg;
  assign illegal_op  = ill_reg;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu (WIDTH=32). Expected results come from a
// behavioural model using 64-bit signed arithmetic; latency and busy length
// are checked per transaction.
// ---------------------------------------------------------------------------
module tb_seq_alu;

  localparam logic [4:0] C_AND  = 5'b00101;
  localparam logic [4:0] C_OR   = 5'b00110;
  localparam logic [4:0] C_ADD  = 5'b00011;
  localparam logic [4:0] C_SUB  = 5'b00100;
  localparam logic [4:0] C_SHR  = 5'b01001;
  localparam logic [4:0] C_SHRA = 5'b01010;
  localparam logic [4:0] C_SHL  = 5'b01011;
  localparam logic [4:0] C_ROR  = 5'b01000;
  localparam logic [4:0] C_ROL  = 5'b00111;
  localparam logic [4:0] C_NEG  = 5'b10001;
  localparam logic [4:0] C_NOT  = 5'b10010;
  localparam logic [4:0] C_MUL  = 5'b10000;
  localparam logic [4:0] C_DIV  = 5'b01111;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, div_by_zero, illegal_op;
  logic [31:0] Zhigh, Zlow;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  seq_alu dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .opcode      (opcode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Zhigh       (Zhigh),
    .Zlow        (Zlow),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: results from plain signed 64-bit arithmetic.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz, output logic ill, output int lat);
    longint sa, sb, p, q, r;
    logic [63:0] dbl, tmp;
    int amt;
    sa = $signed(a);
    sb = $signed(b);
    amt = int'(b % 32);
    dbl = {a, a};
    hi = '0; lo = '0; dbz = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      C_AND:  lo = a & b;
      C_OR:   lo = a | b;
      C_ADD:  lo = a + b;
      C_SUB:  lo = a - b;
      C_SHR:  lo = a >> amt;
      C_SHRA: begin p = sa >>> amt; lo = p[31:0]; end
      C_SHL:  lo = a << amt;
      C_ROR:  begin tmp = dbl >> amt; lo = tmp[31:0]; end
      C_ROL:  begin tmp = dbl << amt; lo = tmp[63:32]; end
      C_NEG:  lo = 32'd0 - a;
      C_NOT:  lo = ~a;
      C_MUL:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; lat = 33; end
      C_DIV: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0]; lat = 34;
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_hi, e_lo;
    logic e_dbz, e_ill;
    int e_lat, lat, busy_cyc;
    model(op, a, b, e_hi, e_lo, e_dbz, e_ill, e_lat);
    @(negedge clock);
    start = 1'b1; opcode = op; A = a; B = b;
    @(posedge clock); #1;
    // Scramble inputs: the operation must run on the values sampled at start.
    start = 1'b0; opcode = 5'($urandom); A = $urandom; B = $urandom;
    lat = 1; busy_cyc = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cyc++;
      @(posedge clock); #1;
      lat++;
    end
    $display("op=%b a=%h b=%h hi=%h lo=%h dbz=%b ill=%b lat=%0d",
             op, a, b, Zhigh, Zlow, div_by_zero, illegal_op, lat);
    chk("done_seen", 64'(done), 64'(1));
    chk("latency", 64'(lat), 64'(e_lat));
    chk("busy_cycles", 64'(busy_cyc), 64'(e_lat - 1));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("Zhigh", 64'(Zhigh), 64'(e_hi));
    chk("Zlow", 64'(Zlow), 64'(e_lo));
    chk("div_by_zero", 64'(div_by_zero), 64'(e_dbz));
    chk("illegal_op", 64'(illegal_op), 64'(e_ill));
    @(posedge clock); #1;
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("Zlow_hold", 64'(Zlow), 64'(e_lo));
  endtask

  logic [4:0] op_tab [14] = '{C_AND, C_OR, C_ADD, C_SUB, C_SHR, C_SHRA, C_SHL,
                              C_ROR, C_ROL, C_NEG, C_NOT, C_MUL, C_DIV, 5'b11111};

  initial begin
    logic [31:0] e_hi, e_lo, cap_hi, cap_lo;
    logic e_dbz, e_ill;
    int e_lat, done_cnt, first_done;

    // Reset state
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_Zhigh", 64'(Zhigh), 64'(0));
    chk("rst_Zlow", 64'(Zlow), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    chk("rst_ill", 64'(illegal_op), 64'(0));
    repeat (2) @(negedge clock);
    clear = 1'b0;

    // Directed cases
    run_op(C_ADD,  32'h7FFF_FFFF, 32'd1);
    run_op(C_MUL,  32'hFFFF_FFFD, 32'd7);
    run_op(C_DIV,  32'hFFFF_FFEF, 32'd5);
    run_op(C_DIV,  32'hFFFF_FFEF, 32'd0);
    run_op(C_ROL,  32'h8000_0001, 32'd33);
    run_op(C_SHRA, 32'h8000_0000, 32'd4);
    run_op(C_SHL,  32'h1234_5678, 32'd0);
    run_op(C_ROR,  32'h1234_5678, 32'd32);
    run_op(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(C_MUL,  32'h8000_0000, 32'h8000_0000);
    run_op(5'b11111, 32'h1, 32'h2);
    run_op(C_SUB,  32'd0, 32'd1);

    // Start during MUL (cycle 10) and during DONE (cycle 33) must be ignored.
    model(C_MUL, 32'h0001_2345, 32'hFFFF_0F0F, e_hi, e_lo, e_dbz, e_ill, e_lat);
    @(negedge clock);
    start = 1'b1; opcode = C_MUL; A = 32'h0001_2345; B = 32'hFFFF_0F0F;
    @(posedge clock); #1;
    start = 1'b0;
    done_cnt = 0; first_done = 0; cap_hi = '0; cap_lo = '0;
    for (int c = 1; c <= 45; c++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = c; cap_hi = Zhigh; cap_lo = Zlow;
        end
      end
      if (c == 10 || c == 33) begin
        start = 1'b1; opcode = C_ADD; A = 32'd5; B = 32'd6;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    $display("mul with ignored starts: hi=%h lo=%h dones=%0d at=%0d", cap_hi, cap_lo, done_cnt, first_done);
    chk("ign_done_count", 64'(done_cnt), 64'(1));
    chk("ign_latency", 64'(first_done), 64'(33));
    chk("ign_product", {cap_hi, cap_lo}, {e_hi, e_lo});
    chk("ign_Zlow_hold", 64'(Zlow), 64'(e_lo));

    // Clear during a MUL aborts at once, with no later done.
    @(negedge clock);
    start = 1'b1; opcode = C_MUL; A = 32'd1000; B = 32'd1000;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clock); #1; end
    chk("pre_clear_busy", 64'(busy), 64'(1));
    clear = 1'b1;
    #1;
    $display("clear mid-mul: busy=%b done=%b hi=%h lo=%h", busy, done, Zhigh, Zlow);
    chk("clr_busy", 64'(busy), 64'(0));
    chk("clr_done", 64'(done), 64'(0));
    chk("clr_Zhigh", 64'(Zhigh), 64'(0));
    chk("clr_Zlow", 64'(Zlow), 64'(0));
    @(negedge clock);
    clear = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    chk("clr_no_done", 64'(done_cnt), 64'(0));
    chk("clr_Zlow_after", 64'(Zlow), 64'(0));

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = op_tab[$urandom_range(0, 13)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(0, 70);
        default: ;
      endcase
      run_op(op, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
